// File: rtl/zone_alarm_pkg.sv
// rtl/zone_alarm_pkg.sv - shared state encodings and default widths for the zone alarm controller
//
// Purpose : common definitions imported by zone_alarm_ctrl and alarm_sec_timer.
// Contents: alarm_state_t (3-bit FSM encoding shown on the display), default
//           parameter values for zone count, delay width and event counter width.
package zone_alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_WAIT_OPEN   = 3'd1,
        ST_WAIT_CLOSE  = 3'd2,
        ST_ARM_DELAY   = 3'd3,
        ST_ARMED       = 3'd4,
        ST_ENTRY_DELAY = 3'd5,
        ST_ALARM_ON    = 3'd6,
        ST_ALARM_HOLD  = 3'd7
    } alarm_state_t;

    localparam int DEF_N_ZONES = 4;
    localparam int DEF_TW      = 4;
    localparam int DEF_CW      = 4;

endpackage

// File: rtl/alarm_sec_timer.sv
// rtl/alarm_sec_timer.sv - loadable seconds down-counter shared by all alarm delays
//
// Purpose : holds the remaining seconds of whichever delay the FSM is running.
// Ports   : clock, reset (async, active-high)
//           load      - load load_val this edge (takes precedence over tick)
//           load_val  - value to load, seconds
//           tick      - one-clock 1 Hz strobe; decrements while nonzero
//           cnt       - current count
//           expired   - cnt == 0
module alarm_sec_timer
    import zone_alarm_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic [TW-1:0] cnt,
    output logic          expired
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign cnt     = r_cnt;
    assign expired = (r_cnt == '0);

endmodule

// File: rtl/zone_alarm_ctrl.sv
// rtl/zone_alarm_ctrl.sv - multi-zone passive-arming alarm controller
//
// Purpose : N-zone door/sensor alarm FSM with passive arming, entry delay,
//           instant-trip zones, trip-zone latch and saturating alarm counter.
// Ports   : clock, reset (async, active-high), tick_1hz (1 s strobe)
//           ignition, reprogram, zone_open[N_ZONES], instant_mask[N_ZONES]
//           t_arm, t_driver, t_pass, t_alarm - delays in seconds (TW bits)
//           state (3-bit FSM state), status (LED), siren_en, expired,
//           trigger_zones (zones that caused the trip), alarm_count (CW bits)
module zone_alarm_ctrl
    import zone_alarm_pkg::*;
#(
    parameter int N_ZONES = DEF_N_ZONES,
    parameter int TW      = DEF_TW,
    parameter int CW      = DEF_CW
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               ignition,
    input  logic               reprogram,
    input  logic [N_ZONES-1:0] zone_open,
    input  logic [N_ZONES-1:0] instant_mask,
    input  logic [TW-1:0]      t_arm,
    input  logic [TW-1:0]      t_driver,
    input  logic [TW-1:0]      t_pass,
    input  logic [TW-1:0]      t_alarm,
    output logic [2:0]         state,
    output logic               status,
    output logic               siren_en,
    output logic               expired,
    output logic [N_ZONES-1:0] trigger_zones,
    output logic [CW-1:0]      alarm_count
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    alarm_state_t       r_state;
    logic               r_blink;
    logic [N_ZONES-1:0] r_trig;
    logic [CW-1:0]      r_count;

    alarm_state_t       w_next;
    logic               w_load;
    logic [TW-1:0]      w_load_val;
    logic [TW-1:0]      w_cnt;
    logic               w_expired;
    logic               w_any;
    logic               w_inst;
    logic               w_alarm_evt;
    logic               w_trig_active;

    assign w_any  = |zone_open;
    assign w_inst = |(zone_open & instant_mask);

    alarm_sec_timer #(
        .TW(TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick_1hz),
        .cnt      (w_cnt),
        .expired  (w_expired)
    );

    // Next-state and timer-load decision; the load happens on the same edge
    // as the transition so the new state starts with the full delay.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        if (reprogram) begin
            w_next = ST_ARMED;
            w_load = 1'b1;
        end else if (ignition && (r_state != ST_DISARMED)) begin
            w_next = ST_DISARMED;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (!ignition) w_next = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (zone_open[0]) w_next = ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    if (!w_any) begin
                        w_next     = ST_ARM_DELAY;
                        w_load     = 1'b1;
                        w_load_val = t_arm;
                    end
                end
                ST_ARM_DELAY: begin
                    if (w_any)          w_next = ST_WAIT_CLOSE;
                    else if (w_expired) w_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_inst) begin
                        w_next     = ST_ALARM_ON;
                        w_load     = 1'b1;
                        w_load_val = t_alarm;
                    end else if (zone_open[0]) begin
                        w_next     = ST_ENTRY_DELAY;
                        w_load     = 1'b1;
                        w_load_val = t_driver;
                    end else if (w_any) begin
                        w_next     = ST_ENTRY_DELAY;
                        w_load     = 1'b1;
                        w_load_val = t_pass;
                    end
                end
                ST_ENTRY_DELAY: begin
                    // Further non-instant openings neither trip nor restart the delay.
                    if (w_inst || w_expired) begin
                        w_next     = ST_ALARM_ON;
                        w_load     = 1'b1;
                        w_load_val = t_alarm;
                    end
                end
                ST_ALARM_ON: begin
                    if (!w_any) begin
                        w_next     = ST_ALARM_HOLD;
                        w_load     = 1'b1;
                        w_load_val = t_alarm;
                    end
                end
                ST_ALARM_HOLD: begin
                    // Re-opening during hold re-sounds without restarting the count.
                    if (w_any)          w_next = ST_ALARM_ON;
                    else if (w_expired) w_next = ST_ARMED;
                end
                default: ;
            endcase
        end
    end

    // Only a fresh trip counts; HOLD -> ON is the same alarm event.
    assign w_alarm_evt   = (w_next == ST_ALARM_ON) &&
                           ((r_state == ST_ARMED) || (r_state == ST_ENTRY_DELAY));
    assign w_trig_active = (r_state == ST_ARMED) || (r_state == ST_ENTRY_DELAY) ||
                           (r_state == ST_ALARM_ON);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARMED;
            r_blink <= 1'b0;
            r_trig  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;

            // Blink phase restarts at 0 every time ARMED is entered.
            if (w_next != ST_ARMED) begin
                r_blink <= 1'b0;
            end else if ((r_state == ST_ARMED) && tick_1hz) begin
                r_blink <= ~r_blink;
            end

            if ((w_next == ST_ARMED) && ((r_state != ST_ARMED) || reprogram)) begin
                r_trig <= '0;
            end else if (w_trig_active) begin
                r_trig <= r_trig | zone_open;
            end

            if (w_alarm_evt && (r_count != CNT_MAX)) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign state         = r_state;
    assign siren_en      = (r_state == ST_ALARM_ON) || (r_state == ST_ALARM_HOLD);
    assign status        = (r_state == ST_ARMED) ? r_blink :
                           ((r_state == ST_ENTRY_DELAY) || siren_en);
    assign expired       = (w_cnt == '0);
    assign trigger_zones = r_trig;
    assign alarm_count   = r_count;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// tb/tb_zone_alarm_ctrl.sv - self-checking bench for zone_alarm_ctrl
module tb_zone_alarm_ctrl;
    import zone_alarm_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       ignition;
    logic       reprogram;
    logic [3:0] zone_open;
    logic [3:0] instant_mask;
    logic [3:0] t_arm;
    logic [3:0] t_driver;
    logic [3:0] t_pass;
    logic [3:0] t_alarm;
    logic [2:0] state;
    logic       status;
    logic       siren_en;
    logic       expired;
    logic [3:0] trigger_zones;
    logic [1:0] alarm_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       sir;
        logic       led;
    } exp_t;

    exp_t q[$];
    exp_t e;

    zone_alarm_ctrl #(
        .N_ZONES(4),
        .TW     (4),
        .CW     (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tick_1hz      (tick_1hz),
        .ignition      (ignition),
        .reprogram     (reprogram),
        .zone_open     (zone_open),
        .instant_mask  (instant_mask),
        .t_arm         (t_arm),
        .t_driver      (t_driver),
        .t_pass        (t_pass),
        .t_alarm       (t_alarm),
        .state         (state),
        .status        (status),
        .siren_en      (siren_en),
        .expired       (expired),
        .trigger_zones (trigger_zones),
        .alarm_count   (alarm_count)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [2:0] s, input logic r, input logic l);
        exp_t x;
        x.st  = s;
        x.sir = r;
        x.led = l;
        return x;
    endfunction

    function automatic exp_t obs();
        return mk(state, siren_en, status);
    endfunction

    // Drive one clock of stimulus and record what the DUT must show afterwards.
    task automatic step(input logic tk, input exp_t x);
        tick_1hz = tk;
        q.push_back(x);
        @(posedge clock);
        #1;
        tick_1hz = 1'b0;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 3) exp_cnt++;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        tick_1hz     = 1'b0;
        ignition     = 1'b0;
        reprogram    = 1'b0;
        zone_open    = 4'b0000;
        instant_mask = 4'b0000;
        t_arm        = 4'd3;
        t_driver     = 4'd2;
        t_pass       = 4'd1;
        t_alarm      = 4'd2;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (obs() !== mk(ST_ARMED, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs(), mk(ST_ARMED, 1'b0, 1'b0));
        end
        checks++;
        if ({expired, trigger_zones, alarm_count} !== {1'b1, 4'b0000, 2'b00}) begin
            failures++;
            $display("FAIL reset_regs got=%b exp=%b", {expired, trigger_zones, alarm_count}, 7'b1000000);
        end
    endtask

    task automatic test_passive_arm();
        logic       ig [0:10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] zn [0:10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       tk [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] st [0:10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic       ex [0:10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i <= 10; i++) begin
            ignition  = ig[i];
            zone_open = zn[i];
            step(tk[i], mk(st[i], 1'b0, 1'b0));
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL passive_arm[%0d] got=%b exp=%b", i, obs(), e);
            end
            checks++;
            if (expired !== ex[i]) begin
                failures++;
                $display("FAIL passive_arm_expired[%0d] got=%b exp=%b", i, expired, ex[i]);
            end
        end
    endtask

    task automatic test_driver_entry();
        zone_open = 4'b0001;
        step(1'b0, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL drv_enter got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL drv_tick1 got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || expired !== 1'b1) begin
            failures++; $display("FAIL drv_tick2 got=%b/%b exp=%b/1", obs(), expired, e);
        end
        bump_cnt();
        step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL drv_alarm got=%b exp=%b", obs(), e); end
        checks++;
        if (alarm_count !== 2'(exp_cnt) || trigger_zones !== 4'b0001) begin
            failures++; $display("FAIL drv_latch got=%0d/%b exp=%0d/0001", alarm_count, trigger_zones, exp_cnt);
        end
        zone_open = 4'b0000;
        reprogram = 1'b1;
        step(1'b0, mk(ST_ARMED, 1'b0, 1'b0));
        reprogram = 1'b0;
        e = q.pop_front(); checks++;
        if (obs() !== e || trigger_zones !== 4'b0000) begin
            failures++; $display("FAIL drv_reprog got=%b/%b exp=%b/0000", obs(), trigger_zones, e);
        end
        zone_open = 4'b0001;
        step(1'b0, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL ign_enter got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL ign_tick got=%b exp=%b", obs(), e); end
        ignition = 1'b1;
        step(1'b0, mk(ST_DISARMED, 1'b0, 1'b0));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL ign_disarm got=%b exp=%b", obs(), e); end
        checks++;
        if (trigger_zones !== 4'b0001 || alarm_count !== 2'(exp_cnt)) begin
            failures++; $display("FAIL ign_held got=%b/%0d exp=0001/%0d", trigger_zones, alarm_count, exp_cnt);
        end
        zone_open = 4'b0000;
        reprogram = 1'b1;
        step(1'b0, mk(ST_ARMED, 1'b0, 1'b0));
        reprogram = 1'b0;
        ignition  = 1'b0;
        e = q.pop_front(); checks++;
        if (obs() !== e || trigger_zones !== 4'b0000) begin
            failures++; $display("FAIL reprog_over_ign got=%b/%b exp=%b/0000", obs(), trigger_zones, e);
        end
    endtask

    task automatic test_instant();
        instant_mask = 4'b1000;
        zone_open    = 4'b1000;
        bump_cnt();
        step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL instant_state got=%b exp=%b", obs(), e); end
        checks++;
        if (trigger_zones !== 4'b1000 || alarm_count !== 2'(exp_cnt)) begin
            failures++; $display("FAIL instant_latch got=%b/%0d exp=1000/%0d", trigger_zones, alarm_count, exp_cnt);
        end
    endtask

    task automatic test_hold_rearm();
        t_alarm   = 4'd2;
        zone_open = 4'b0000;
        step(1'b0, mk(ST_ALARM_HOLD, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL hold_enter got=%b exp=%b", obs(), e); end
        zone_open = 4'b0100;
        step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || alarm_count !== 2'(exp_cnt)) begin
            failures++; $display("FAIL hold_reopen got=%b/%0d exp=%b/%0d", obs(), alarm_count, e, exp_cnt);
        end
        zone_open = 4'b0000;
        step(1'b0, mk(ST_ALARM_HOLD, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL hold_again got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ALARM_HOLD, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL hold_tick1 got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ALARM_HOLD, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL hold_tick2 got=%b exp=%b", obs(), e); end
        step(1'b0, mk(ST_ARMED, 1'b0, 1'b0));
        e = q.pop_front(); checks++;
        if (obs() !== e || trigger_zones !== 4'b0000 || alarm_count !== 2'(exp_cnt)) begin
            failures++; $display("FAIL hold_rearm got=%b/%b/%0d exp=%b/0000/%0d", obs(), trigger_zones, alarm_count, e, exp_cnt);
        end
    endtask

    task automatic test_saturation_reset();
        for (int k = 0; k < 3; k++) begin
            zone_open = 4'b1000;
            bump_cnt();
            step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
            e = q.pop_front(); checks++;
            if (obs() !== e || alarm_count !== 2'(exp_cnt)) begin
                failures++; $display("FAIL sat_%0d got=%b/%0d exp=%b/%0d", k, obs(), alarm_count, e, exp_cnt);
            end
            zone_open = 4'b0000;
            reprogram = 1'b1;
            step(1'b0, mk(ST_ARMED, 1'b0, 1'b0));
            reprogram = 1'b0;
            e = q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL sat_rearm_%0d got=%b exp=%b", k, obs(), e); end
        end
        zone_open = 4'b1000;
        step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || alarm_count !== 2'd3) begin
            failures++; $display("FAIL sat_hold got=%b/%0d exp=%b/3", obs(), alarm_count, e);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        checks++;
        if (obs() !== mk(ST_ARMED, 1'b0, 1'b0) || alarm_count !== 2'd0 || trigger_zones !== 4'b0000) begin
            failures++; $display("FAIL async_reset got=%b/%0d/%b exp=%b/0/0000", obs(), alarm_count, trigger_zones, mk(ST_ARMED, 1'b0, 1'b0));
        end
        zone_open = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_blink();
        logic b = 1'b0;
        for (int t = 0; t < 3; t++) begin
            b = ~b;
            step(1'b1, mk(ST_ARMED, 1'b0, b));
            for (int c = 0; c < 3; c++) step(1'b0, mk(ST_ARMED, 1'b0, b));
            for (int c = 0; c < 4; c++) begin
                e = q.pop_front(); checks++;
                if (obs() !== e && c == 0) begin failures++; $display("FAIL blink_tick_%0d got=%b exp=%b", t, obs(), e); end
            end
            checks = checks - 3;
        end
        t_pass    = 4'd1;
        zone_open = 4'b0010;
        step(1'b1, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || expired !== 1'b0) begin
            failures++; $display("FAIL pass_load_wins got=%b/%b exp=%b/0", obs(), expired, e);
        end
        step(1'b1, mk(ST_ENTRY_DELAY, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || expired !== 1'b1) begin
            failures++; $display("FAIL pass_tick got=%b/%b exp=%b/1", obs(), expired, e);
        end
        bump_cnt();
        step(1'b0, mk(ST_ALARM_ON, 1'b1, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e || alarm_count !== 2'(exp_cnt) || trigger_zones !== 4'b0010) begin
            failures++; $display("FAIL pass_alarm got=%b/%0d/%b exp=%b/%0d/0010", obs(), alarm_count, trigger_zones, e, exp_cnt);
        end
        zone_open = 4'b0000;
        reprogram = 1'b1;
        step(1'b0, mk(ST_ARMED, 1'b0, 1'b0));
        reprogram = 1'b0;
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL blink_cleared got=%b exp=%b", obs(), e); end
        step(1'b1, mk(ST_ARMED, 1'b0, 1'b1));
        e = q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL blink_restart got=%b exp=%b", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_passive_arm();
        test_driver_entry();
        test_instant();
        test_hold_rearm();
        test_saturation_reset();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
